// File: rtl/sobel_window_core.sv
// Streaming 3x3 Sobel stage: two line buffers feed a shifting window, and |Gx|+|Gy|
// is saturated to the pixel width and emitted once for every interior pixel of a frame.
module sobel_window_core #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    input  logic                   px_valid_i,
    input  logic [PIXEL_WIDTH-1:0] px_gray_i,
    output logic                   px_valid_o,
    output logic [PIXEL_WIDTH-1:0] px_sobel_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int SUM_W = PIXEL_WIDTH + 3;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PROC, ST_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       drain_q, drain_d;
    logic             start_ok, frame_done;
    logic             accept, last_px, emit;

    logic [PIXEL_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q;
    logic                   win_vld_q;
    logic                   px_valid_q;
    logic [PIXEL_WIDTH-1:0] sobel_q;

    logic [SUM_W-1:0]       gx_pos, gx_neg, gy_pos, gy_neg;
    logic [SUM_W-1:0]       gx_diff, gy_diff, ax, ay;
    logic [SUM_W:0]         mag;
    logic [PIXEL_WIDTH-1:0] mag_sat;

    assign accept  = (state_q == ST_PROC) && px_valid_i;
    assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign emit    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        start_ok   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    state_d  = ST_PROC;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            ST_PROC: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_px) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last window reach the output register; the third signals done.
                if (drain_q == 2'd2) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    // Line buffers are left unreset; the row/col gating keeps stale contents from being emitted.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= px_gray_i;
        end
    end

    always_comb begin
        gx_pos  = SUM_W'(win_q[0][2]) + (SUM_W'(win_q[1][2]) << 1) + SUM_W'(win_q[2][2]);
        gx_neg  = SUM_W'(win_q[0][0]) + (SUM_W'(win_q[1][0]) << 1) + SUM_W'(win_q[2][0]);
        gy_pos  = SUM_W'(win_q[2][0]) + (SUM_W'(win_q[2][1]) << 1) + SUM_W'(win_q[2][2]);
        gy_neg  = SUM_W'(win_q[0][0]) + (SUM_W'(win_q[0][1]) << 1) + SUM_W'(win_q[0][2]);
        gx_diff = gx_pos - gx_neg;
        gy_diff = gy_pos - gy_neg;
        ax      = gx_diff[SUM_W-1] ? (~gx_diff + SUM_W'(1)) : gx_diff;
        ay      = gy_diff[SUM_W-1] ? (~gy_diff + SUM_W'(1)) : gy_diff;
        mag     = {1'b0, ax} + {1'b0, ay};
        mag_sat = (|mag[SUM_W:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            win_q      <= '0;
            win_vld_q  <= 1'b0;
            px_valid_q <= 1'b0;
            sobel_q    <= '0;
        end else begin
            win_vld_q  <= emit;
            px_valid_q <= win_vld_q;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_q[col_q];
                win_q[1][2] <= lb0_q[col_q];
                win_q[2][2] <= px_gray_i;
            end
            if (win_vld_q) begin
                sobel_q <= mag_sat;
            end else if (start_ok) begin
                sobel_q <= '0;
            end
        end
    end

    assign px_valid_o   = px_valid_q;
    assign px_sobel_o   = sobel_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done;

endmodule

// File: tb/tb_sobel_window_core.sv
// Directed bench for sobel_window_core on an 8x6 image: table of frame patterns with
// hand-computed per-column magnitudes, plus reset-abort and ignored-control sequences.
module tb_sobel_window_core;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk_i = 1'b0;
    logic       nreset_i;
    logic       start_i;
    logic       px_valid_i;
    logic [7:0] px_gray_i;
    logic       px_valid_o;
    logic [7:0] px_sobel_o;
    logic       busy_o;
    logic       frame_done_o;

    sobel_window_core #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .start_i      (start_i),
        .px_valid_i   (px_valid_i),
        .px_gray_i    (px_gray_i),
        .px_valid_o   (px_valid_o),
        .px_sobel_o   (px_sobel_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    // scoreboard state
    logic [7:0] exp_q[$];
    int         acc_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_out = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    int         last_acc = 0;

    // pattern ids: 0 flat 100, 1 vertical step, 2 ramp c*2, 3 c*2+r*10, 4 100-3c, 5 r*50
    typedef struct {
        int              pat;
        int              gap;
        logic [5:0][7:0] exp_c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        int v;
        case (pat)
            0:       v = 100;
            1:       v = (c < 4) ? 0 : 255;
            2:       v = c * 2;
            3:       v = c * 2 + r * 10;
            4:       v = 100 - c * 3;
            default: v = r * 50;
        endcase
        return v[7:0];
    endfunction

    always @(negedge clk_i) begin
        if (px_valid_o) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0d expected no output (t=%0t)", px_sobel_o, $time);
            end else begin
                logic [7:0] e;
                int a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("sobel_value", int'(px_sobel_o), int'(e));
                check("out_latency", cyc - a, 2);
            end
        end
        if (frame_done_o) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // driver tasks (called at #1 after a rising edge)
    task automatic start_frame();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_after_start", int'(busy_o), 1);
        check("sobel_cleared_on_start", int'(px_sobel_o), 0);
    endtask

    task automatic drive_pixels(input int pat, input int gap, input logic [5:0][7:0] exp_c,
                                input int n, input bit pokes);
        int cnt;
        cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (cnt < n) begin
                    for (int g = 0; g < gap; g++) begin
                        px_valid_i = 1'b0;
                        start_i    = 1'b0;
                        @(posedge clk_i); #1;
                    end
                    px_valid_i = 1'b1;
                    px_gray_i  = pix(pat, r, c);
                    start_i    = pokes && (c == 5);
                    if (r >= 2 && c >= 2) begin
                        exp_q.push_back(exp_c[c-2]);
                        acc_q.push_back(cyc);
                    end
                    last_acc = cyc;
                    @(posedge clk_i); #1;
                    cnt++;
                end
            end
        end
        px_valid_i = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int gap, input logic [5:0][7:0] exp_c,
                             input bit pokes);
        n_out  = 0;
        n_done = 0;
        start_frame();
        drive_pixels(pat, gap, exp_c, W * H, pokes);
        if (pokes) begin
            // start and pixels held through drain and the done cycle must all be ignored
            start_i    = 1'b1;
            px_valid_i = 1'b1;
            px_gray_i  = 8'd255;
            repeat (3) @(posedge clk_i);
            #1;
            start_i    = 1'b0;
            px_valid_i = 1'b0;
        end
        repeat (6) @(posedge clk_i);
        #1;
        check("output_count", n_out, (W - 2) * (H - 2));
        check("frame_done_count", n_done, 1);
        check("frame_done_delay", done_cyc - last_acc, 3);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_after_frame", int'(busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].pat = 0; vecs[0].gap = 0; vecs[0].exp_c = {6{8'd0}};
        vecs[1].pat = 1; vecs[1].gap = 0; vecs[1].exp_c = {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
        vecs[2].pat = 2; vecs[2].gap = 0; vecs[2].exp_c = {6{8'd16}};
        vecs[3].pat = 2; vecs[3].gap = 2; vecs[3].exp_c = {6{8'd16}};
        vecs[4].pat = 3; vecs[4].gap = 1; vecs[4].exp_c = {6{8'd96}};
        vecs[5].pat = 4; vecs[5].gap = 0; vecs[5].exp_c = {6{8'd24}};
        vecs[6].pat = 5; vecs[6].gap = 0; vecs[6].exp_c = {6{8'd255}};

        nreset_i   = 1'b0;
        start_i    = 1'b0;
        px_valid_i = 1'b0;
        px_gray_i  = 8'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", int'(busy_o), 0);
        check("reset_valid", int'(px_valid_o), 0);
        check("reset_sobel", int'(px_sobel_o), 0);
        check("reset_done", int'(frame_done_o), 0);
        nreset_i = 1'b1;
        @(posedge clk_i); #1;
        check("idle_busy", int'(busy_o), 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].pat, vecs[i].gap, vecs[i].exp_c, 1'b0);
        end

        // pixels offered in IDLE are dropped; start mid-frame and in drain are ignored
        n_out = 0;
        px_valid_i = 1'b1;
        px_gray_i  = 8'd255;
        repeat (5) @(posedge clk_i);
        #1;
        px_valid_i = 1'b0;
        check("idle_pixels_busy", int'(busy_o), 0);
        check("idle_pixels_no_output", n_out, 0);
        run_frame(3, 1, {6{8'd96}}, 1'b1);

        // asynchronous reset mid-frame
        n_out = 0;
        start_frame();
        drive_pixels(2, 0, {6{8'd16}}, 20, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("partial_outputs", n_out, 2);
        check("partial_sobel", int'(px_sobel_o), 16);
        check("partial_busy", int'(busy_o), 1);
        #2;
        nreset_i = 1'b0;
        #1;
        check("async_reset_busy", int'(busy_o), 0);
        check("async_reset_sobel", int'(px_sobel_o), 0);
        check("async_reset_valid", int'(px_valid_o), 0);
        check("async_reset_done", int'(frame_done_o), 0);
        @(posedge clk_i); #1;
        nreset_i = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk_i); #1;
        run_frame(0, 0, {6{8'd0}}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
